// File: rtl/mul_sched.sv
// Round-robin scheduler sharing one external pipelined multiplier among NREQ requesters.
// A credit check against the result FIFO keeps every in-flight product guaranteed a slot.
module mul_sched #(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 4,
  parameter int LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ-1:0]       req_unsign,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  output logic                  mul_unsign,
  input  logic [WIDTH-1:0]      mul_lower,
  input  logic [WIDTH-1:0]      mul_upper,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]      rsp_lower,
  output logic [WIDTH-1:0]      rsp_upper,
  output logic                  busy
);
  localparam int IDW    = $clog2(NREQ);
  localparam int FDEPTH = LATENCY + 2;
  localparam int PW     = $clog2(FDEPTH);
  localparam int CW     = $clog2(FDEPTH + 1);
  localparam int EW     = IDW + 2 * WIDTH;

  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] grant;
  logic           found;
  logic           credit_ok;
  logic           issue;
  logic           push;
  logic           pop;

  logic [LATENCY-1:0] tag_vld;
  logic [IDW-1:0]     tag_id [LATENCY];

  logic [EW-1:0]  fifo_mem [FDEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  fifo_count;
  logic [CW-1:0]  inflight_count;

  always_comb begin : arb
    int idx;
    idx   = 0;
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  always_comb begin
    inflight_count = '0;
    for (int i = 0; i < LATENCY; i++)
      inflight_count = inflight_count + CW'(tag_vld[i]);
  end

  // Credit counts only entries already committed; a pop this cycle frees space next cycle.
  assign credit_ok = (int'(fifo_count) + int'(inflight_count)) < FDEPTH;
  assign issue     = rst_n && found && credit_ok;
  assign push      = tag_vld[LATENCY-1];
  assign pop       = rsp_valid && rsp_ready;

  assign req_ready  = issue ? (NREQ'(1) << grant) : '0;
  assign mul_a      = issue ? req_a[int'(grant)*WIDTH +: WIDTH] : '0;
  assign mul_b      = issue ? req_b[int'(grant)*WIDTH +: WIDTH] : '0;
  assign mul_unsign = issue ? req_unsign[grant] : 1'b0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr     <= '0;
      tag_vld    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (issue)
        rr_ptr <= (int'(grant) == NREQ - 1) ? '0 : grant + 1'b1;
      tag_vld[0] <= issue;
      for (int i = 1; i < LATENCY; i++)
        tag_vld[i] <= tag_vld[i-1];
      if (push)
        wr_ptr <= (wr_ptr == PW'(FDEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= (rd_ptr == PW'(FDEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Tag stage boundary: ids ride alongside the multiplier pipeline, then land in the FIFO.
  always_ff @(posedge clk) begin
    tag_id[0] <= grant;
    for (int i = 1; i < LATENCY; i++)
      tag_id[i] <= tag_id[i-1];
    if (push)
      fifo_mem[wr_ptr] <= {tag_id[LATENCY-1], mul_upper, mul_lower};
  end

  assign {rsp_id, rsp_upper, rsp_lower} = fifo_mem[rd_ptr];
  assign rsp_valid = rst_n && (fifo_count != '0);
  assign busy      = rst_n && ((fifo_count != '0) || (inflight_count != '0));
endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched (WIDTH=16, NREQ=4, LATENCY=1) with a one-cycle multiplier model.
module tb_mul_sched;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [63:0] req_a;
  logic [63:0] req_b;
  logic [3:0]  req_unsign;
  logic [3:0]  req_ready;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_unsign;
  logic [15:0] mul_lower;
  logic [15:0] mul_upper;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_lower;
  logic [15:0] rsp_upper;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] prod;
  logic [15:0] exp_lo [4] = '{16'h2000, 16'h3003, 16'h4008, 16'h500F};

  mul_sched #(.WIDTH(16), .NREQ(4), .LATENCY(1)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_unsign(req_unsign), .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b),
    .mul_unsign(mul_unsign), .mul_lower(mul_lower), .mul_upper(mul_upper),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lower(rsp_lower), .rsp_upper(rsp_upper), .busy(busy)
  );

  always #5 clk = ~clk;

  // External multiplier: one register stage.
  always @(posedge clk) begin
    if (mul_unsign)
      prod <= {16'd0, mul_a} * {16'd0, mul_b};
    else
      prod <= $signed({{16{mul_a[15]}}, mul_a}) * $signed({{16{mul_b[15]}}, mul_b});
  end
  assign mul_lower = prod[15:0];
  assign mul_upper = prod[31:16];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b, input logic u);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
    req_unsign[i]     = u;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; req_valid = 4'hF; req_unsign = 4'hF; rsp_ready = 1'b1;
    req_a = 64'h0123_4567_89AB_CDEF; req_b = 64'hFEDC_BA98_7654_3210;
    nxt; nxt; mid;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_mul_a", 32'(mul_a), 32'h0);
    chk("rst_mul_b", 32'(mul_b), 32'h0);
    chk("rst_mul_unsign", 32'(mul_unsign), 32'h0);
    nxt;
    rst_n = 1'b1; req_valid = 4'h0; req_unsign = 4'h0;
    mid;
    chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // Single signed op from requester 2
    nxt;
    set_op(2, 16'hFFFD, 16'h0005, 1'b0); req_valid = 4'b0100;
    mid;
    chk("single_ready", 32'(req_ready), 32'h4);
    chk("single_mul_a", 32'(mul_a), 32'hFFFD);
    chk("single_mul_b", 32'(mul_b), 32'h0005);
    chk("single_mul_unsign", 32'(mul_unsign), 32'h0);
    nxt; req_valid = 4'h0; mid;
    chk("single_t1_valid", 32'(rsp_valid), 32'h0);
    chk("single_t1_busy", 32'(busy), 32'h1);
    nxt; mid;
    chk("single_t2_valid", 32'(rsp_valid), 32'h1);
    chk("single_t2_id", 32'(rsp_id), 32'h2);
    chk("single_t2_upper", 32'(rsp_upper), 32'hFFFF);
    chk("single_t2_lower", 32'(rsp_lower), 32'hFFF1);
    nxt; mid;
    chk("single_drained_valid", 32'(rsp_valid), 32'h0);
    chk("single_drained_busy", 32'(busy), 32'h0);

    // Unsigned op from requester 1 (rr_ptr is 3, search wraps to 1)
    nxt;
    set_op(1, 16'hFFFF, 16'hFFFF, 1'b1); req_valid = 4'b0010;
    mid;
    chk("unsig_ready", 32'(req_ready), 32'h2);
    chk("unsig_mul_unsign", 32'(mul_unsign), 32'h1);
    nxt; req_valid = 4'h0; nxt; mid;
    chk("unsig_valid", 32'(rsp_valid), 32'h1);
    chk("unsig_id", 32'(rsp_id), 32'h1);
    chk("unsig_upper", 32'(rsp_upper), 32'hFFFE);
    chk("unsig_lower", 32'(rsp_lower), 32'h0001);
    nxt;

    // Reset clears rr_ptr, then fairness run
    rst_n = 1'b0; nxt; rst_n = 1'b1;
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 2), 16'(16'h1000 + i), 1'b0);
    req_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      mid;
      chk($sformatf("fair_ready_%0d", k), 32'(req_ready), 32'(4'b0001 << (k % 4)));
      if (k >= 2) begin
        chk($sformatf("fair_valid_%0d", k), 32'(rsp_valid), 32'h1);
        chk($sformatf("fair_id_%0d", k), 32'(rsp_id), 32'((k - 2) % 4));
        chk($sformatf("fair_lower_%0d", k), 32'(rsp_lower), 32'(exp_lo[(k - 2) % 4]));
        chk($sformatf("fair_upper_%0d", k), 32'(rsp_upper), 32'h0);
      end
      nxt;
    end
    req_valid = 4'h0;
    nxt; nxt; nxt; mid;
    chk("fair_drained_busy", 32'(busy), 32'h0);
    chk("fair_drained_valid", 32'(rsp_valid), 32'h0);

    // Backpressure: exactly three issues, then stall
    nxt;
    rsp_ready = 1'b0; req_valid = 4'hF;
    for (int k = 0; k < 6; k++) begin
      mid;
      chk($sformatf("bp_ready_%0d", k), 32'(req_ready), (k < 3) ? 32'(4'b0001 << k) : 32'h0);
      if (k >= 2) begin
        chk($sformatf("bp_hold_valid_%0d", k), 32'(rsp_valid), 32'h1);
        chk($sformatf("bp_hold_id_%0d", k), 32'(rsp_id), 32'h0);
        chk($sformatf("bp_hold_lower_%0d", k), 32'(rsp_lower), 32'(exp_lo[0]));
      end
      nxt;
    end
    req_valid = 4'h0; rsp_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      mid;
      chk($sformatf("drain_valid_%0d", j), 32'(rsp_valid), 32'h1);
      chk($sformatf("drain_id_%0d", j), 32'(rsp_id), 32'(j));
      chk($sformatf("drain_lower_%0d", j), 32'(rsp_lower), 32'(exp_lo[j]));
      nxt;
    end
    mid;
    chk("drain_done_valid", 32'(rsp_valid), 32'h0);
    chk("drain_done_busy", 32'(busy), 32'h0);

    // Reset mid-flight (rr_ptr is 3)
    nxt;
    req_valid = 4'b0011;
    mid;
    chk("mf_issue0", 32'(req_ready), 32'h1);
    nxt; mid;
    chk("mf_issue1", 32'(req_ready), 32'h2);
    nxt;
    req_valid = 4'h0; rst_n = 1'b0;
    mid;
    chk("mf_rst_valid", 32'(rsp_valid), 32'h0);
    chk("mf_rst_busy", 32'(busy), 32'h0);
    nxt;
    rst_n = 1'b1;
    for (int j = 0; j < 4; j++) begin
      mid;
      chk($sformatf("mf_after_valid_%0d", j), 32'(rsp_valid), 32'h0);
      chk($sformatf("mf_after_busy_%0d", j), 32'(busy), 32'h0);
      nxt;
    end
    req_valid = 4'hF;
    mid;
    chk("mf_next_grant", 32'(req_ready), 32'h1);
    nxt;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
REQ-001 Parameter WIDTH, default 16: operand width; SHALL be even and at least 8.
REQ-002 Parameter NREQ, default 4: number of requesters; SHALL be at least 2.
REQ-003 Parameter LATENCY, default 1: cycles from driving mul_a/mul_b until mul_lower/mul_upper are valid; SHALL be at least 1.
REQ-004 Localparam IDW = $clog2(NREQ); localparam FDEPTH = LATENCY+2, the result FIFO depth.
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst_n  in  1  reset, synchronous, active-low.
REQ-007 req_valid  in  NREQ  per-requester request valid.
REQ-008 req_a, req_b  in  NREQ*WIDTH each  operands; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-009 req_unsign  in  NREQ  1 = unsigned x unsigned, 0 = signed x signed.
REQ-010 req_ready  out  NREQ  grant/accept, one-hot or zero.
REQ-011 mul_a, mul_b  out  WIDTH each  multiplier operands.
REQ-012 mul_unsign  out  1  multiplier sign mode.
REQ-013 mul_lower, mul_upper  in  WIDTH each  multiplier product halves.
REQ-014 rsp_valid  out  1  response valid.
REQ-015 rsp_ready  in  1  response accept.
REQ-016 rsp_id  out  IDW  index of the originating requester.
REQ-017 rsp_lower, rsp_upper  out  WIDTH each  product halves.
REQ-018 busy  out  1  high when any operation is in flight or the FIFO is non-empty.

Function
REQ-019 Arbitration SHALL be round-robin from pointer rr_ptr: grant the first i with req_valid[i] set, searching rr_ptr, rr_ptr+1, ... modulo NREQ.
REQ-020 Credit = FDEPTH - fifo_count - inflight_count, and issue SHALL occur only when credit > 0; a same-cycle FIFO pop SHALL NOT add credit.
REQ-021 req_ready[g] SHALL be asserted combinationally for the granted index g only when issue occurs; all other req_ready bits SHALL be 0.
REQ-022 On issue, rr_ptr SHALL become (g+1) mod NREQ; otherwise rr_ptr SHALL hold.
REQ-023 When issuing, mul_a, mul_b and mul_unsign SHALL equal the granted requester's fields; otherwise they SHALL be all zero.
REQ-024 A tag pipeline of LATENCY stages {valid, id} SHALL shift every cycle; stage 0 is loaded with {issue, g}.
REQ-025 When the last tag stage is valid, {id, mul_upper, mul_lower} SHALL be pushed into the FIFO in that same cycle (LATENCY cycles after issue).
REQ-026 Latency: a handshake in cycle T SHALL give its earliest rsp_valid in cycle T+LATENCY+1.
REQ-027 Responses SHALL return in issue order.
REQ-028 rsp_* SHALL present the FIFO head, with rsp_valid = !empty.
REQ-029 A pop SHALL occur when rsp_valid && rsp_ready; rsp_* SHALL stay stable while rsp_valid && !rsp_ready.
REQ-030 Simultaneous push and pop SHALL leave fifo_count unchanged; the credit rule guarantees the FIFO never overflows.
REQ-031 FIFO and tag pointers SHALL wrap modulo their depth.
REQ-032 With rsp_ready held high, the block SHALL sustain one issue per cycle indefinitely.
REQ-033 inflight_count SHALL be the number of valid tag stages, range 0..LATENCY.

Reset
REQ-034 While rst_n = 0 at a clock edge: rr_ptr = 0, all tag valids = 0, FIFO empty, inflight_count = 0.
REQ-035 During and after reset: rsp_valid = 0, req_ready = 0, busy = 0, mul_a = mul_b = 0, mul_unsign = 0.
REQ-036 Reset mid-operation SHALL discard all in-flight and queued results; no response for them SHALL appear after reset release.

Verification
REQ-037 Single op: WIDTH=16, LATENCY=1, requester 2 signed a=0xFFFD, b=0x0005 -> handshake in T; in T+2, rsp_valid=1, rsp_id=2, upper=0xFFFF, lower=0xFFF1.
REQ-038 Unsigned op: a=0xFFFF, b=0xFFFF, unsign=1 -> upper=0xFFFE, lower=0x0001.
REQ-039 Fairness: all 4 requesters valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0,... with one grant every cycle and no gaps.
REQ-040 Backpressure: rsp_ready=0 with requesters valid -> exactly FDEPTH issues (3 for LATENCY=1), then req_ready stays 0; raising rsp_ready drains all three in order with operands and ids intact.
REQ-041 Reset mid-flight: issue 2 ops, assert rst_n=0 for one cycle on the cycle after the second issue -> no rsp_valid afterwards; busy=0; next grant goes to requester 0.
